// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and iteration count for the multiply/divide unit.
package muldiv_pkg;
    localparam int ITER = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring shift-subtract divide iteration on a 2*WIDTH working value.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_work,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_is_div,
    output logic [2*WIDTH-1:0] o_next
);
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_mul;
    logic [2*WIDTH-1:0] w_div;
    always_comb begin
        w_sum    = {1'b0, i_work[2*WIDTH-1:WIDTH]} + (i_work[0] ? {1'b0, i_operand} : '0);
        w_mul    = {w_sum, i_work[WIDTH-1:1]};
        // shifted remainder needs WIDTH+1 bits; a borrow in the top bit means "restore"
        w_rem_sh = i_work[2*WIDTH-1:WIDTH-1];
        w_diff   = w_rem_sh - {1'b0, i_operand};
        w_div    = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], i_work[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], i_work[WIDTH-2:0], 1'b1};
        o_next   = i_is_div ? w_div : w_mul;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers; 34-cycle start-to-done latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = muldiv_pkg::ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER);
    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg;
    logic               r_sign_a;
    logic               r_bzero;
    logic               r_done;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic [2*WIDTH-1:0] w_next;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_work    (r_work),
        .i_operand (r_operand),
        .i_is_div  (r_is_div),
        .o_next    (w_next)
    );

    always_comb begin
        w_signed = ~op[0];
        w_is_div = op[1];
        w_mag_a  = (w_signed && A[WIDTH-1]) ? -A : A;
        w_mag_b  = (w_signed && B[WIDTH-1]) ? -B : B;
        w_prod   = r_neg ? -r_work : r_work;
        // divide by zero leaves an all-ones quotient regardless of the dividend sign
        w_quot   = r_bzero ? '1 : (r_neg ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0]);
        w_rem    = r_sign_a ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];
        w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg     <= 1'b0;
            r_sign_a  <= 1'b0;
            r_bzero   <= 1'b0;
            r_done    <= 1'b0;
            r_work    <= '0;
            r_operand <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state   <= S_CALC;
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_sign_a  <= w_signed & A[WIDTH-1];
                        r_neg     <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_bzero   <= w_is_div & (B == '0);
                        r_work    <= {{WIDTH{1'b0}}, w_is_div ? w_mag_a : w_mag_b};
                        r_operand <= w_is_div ? w_mag_b : w_mag_a;
                    end else if (!start) begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_CALC: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (abort) r_state <= S_IDLE;
                    else if (r_cnt == CW'(ITER - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!abort) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
